// File: rtl/msk_frame_sync.sv
`default_nettype none
// ============================================================================
// msk_frame_sync : error-tolerant sync-word search and MSB-first payload packer
// Optional feature macro: FRAME_SYNC_INV_EN (also accept the inverted sync word)
// Revision: 1.0
// ============================================================================
module msk_frame_sync #(
  parameter logic [31:0] SYNC_WORD   = 32'h1ACF_FC1D,
  parameter int          SYNC_LEN    = 32,
  parameter int          MAX_ERR     = 2,
  parameter int          FRAME_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bit_in,
  input  logic        bit_val,
  output logic [7:0]  byte_out,
  output logic        byte_val,
  output logic        sof,
  output logic        eof,
  output logic        locked,
  output logic        inverted,
  output logic [15:0] frame_cnt
);

  localparam int                  BCW       = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int                  CW        = $clog2(SYNC_LEN + 1);
  localparam logic [BCW-1:0]      LAST_BYTE = BCW'(FRAME_BYTES - 1);
  localparam logic [CW-1:0]       SL_C      = CW'(SYNC_LEN);
  localparam logic [CW-1:0]       ERR_C     = CW'(MAX_ERR);
  localparam logic [SYNC_LEN-1:0] PATTERN   = SYNC_WORD[SYNC_LEN-1:0];

  typedef enum logic [0:0] {
    SEARCH  = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  state_t              state;
  // Only SYNC_LEN-1 history bits are kept: the oldest bit falls out on the next shift.
  logic [SYNC_LEN-2:0] sreg;
  logic [SYNC_LEN-1:0] nsreg;
  logic [SYNC_LEN-1:0] diff;
  logic [CW-1:0]       fill;
  logic [CW-1:0]       err_cnt;
  logic [2:0]          bit_cnt;
  logic [BCW-1:0]      byte_cnt;
  logic [7:0]          acc;
  logic [7:0]          acc_next;
  logic                fill_ok;
  logic                true_match;
  logic                inv_match;
  logic                match;

  always_comb begin
    nsreg   = {sreg, bit_in};
    diff    = nsreg ^ PATTERN;
    err_cnt = '0;
    for (int i = 0; i < SYNC_LEN; i++) begin
      err_cnt = err_cnt + CW'(diff[i]);
    end
  end

  assign fill_ok    = (fill >= CW'(SYNC_LEN - 1));
  assign true_match = (err_cnt <= ERR_C);
  assign match      = fill_ok & (true_match | inv_match);
  assign acc_next   = {acc[6:0], bit_in ^ inverted};

`ifdef FRAME_SYNC_INV_EN
  // Distance of ~nsreg from the pattern is the complement of the true distance.
  assign inv_match = ((SL_C - err_cnt) <= ERR_C);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inverted <= 1'b0;
    end else if (bit_val && (state == SEARCH) && match) begin
      inverted <= ~true_match;
    end
  end
`else
  assign inv_match = 1'b0;
  assign inverted  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SEARCH;
      sreg      <= '0;
      fill      <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      acc       <= '0;
      byte_out  <= '0;
      byte_val  <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
      locked    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      byte_val <= 1'b0;
      sof      <= 1'b0;
      eof      <= 1'b0;
      if (bit_val) begin
        case (state)
          SEARCH: begin
            sreg <= nsreg[SYNC_LEN-2:0];
            if (fill != SL_C) begin
              fill <= fill + CW'(1);
            end
            if (match) begin
              state    <= PAYLOAD;
              locked   <= 1'b1;
              bit_cnt  <= '0;
              byte_cnt <= '0;
            end
          end
          PAYLOAD: begin
            acc     <= acc_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              byte_out <= acc_next;
              byte_val <= 1'b1;
              sof      <= (byte_cnt == '0);
              if (byte_cnt == LAST_BYTE) begin
                eof       <= 1'b1;
                frame_cnt <= frame_cnt + 16'd1;
                state     <= SEARCH;
                locked    <= 1'b0;
                fill      <= '0;
              end else begin
                byte_cnt <= byte_cnt + BCW'(1);
              end
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_msk_frame_sync.sv
`default_nettype none
// tb_msk_frame_sync : directed and randomized frames checked cycle-by-cycle
// against a bit-stream reference model of the frame synchronizer.
module tb_msk_frame_sync;

  localparam int SYNC_LEN = 32;
  localparam int MAX_ERR  = 2;
  localparam int FB       = 4;
  localparam int MAXB     = 1024;
`ifdef FRAME_SYNC_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        bit_in  = 1'b0;
  logic        bit_val = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_val;
  logic        sof;
  logic        eof;
  logic        locked;
  logic        inverted;
  logic [15:0] frame_cnt;

  msk_frame_sync #(
    .SYNC_WORD  (32'h1ACFFC1D),
    .SYNC_LEN   (SYNC_LEN),
    .MAX_ERR    (MAX_ERR),
    .FRAME_BYTES(FB)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bit_in   (bit_in),
    .bit_val  (bit_val),
    .byte_out (byte_out),
    .byte_val (byte_val),
    .sof      (sof),
    .eof      (eof),
    .locked   (locked),
    .inverted (inverted),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stimulus stream and the model's per-bit expectations
  logic [31:0] sw = 32'h1ACFFC1D;
  bit          strm   [MAXB];
  int          slen;
  bit          body   [$];
  bit          e_bv   [MAXB];
  bit          e_sof  [MAXB];
  bit          e_eof  [MAXB];
  bit          e_lock [MAXB];
  bit          e_inv  [MAXB];
  logic [7:0]  e_byte [MAXB];
  logic [15:0] e_fcnt [MAXB];
  int          m_frames;

  // Reference: scan the whole bit stream, frame by frame, with plain arithmetic.
  task automatic run_model();
    bit         searching = 1'b1;
    bit         inv = 1'b0;
    int         start = 0;
    int         pstart = 0;
    int         fc = 0;
    int         d;
    int         p;
    int         b;
    logic [7:0] v;
    m_frames = 0;
    for (int k = 0; k < slen; k++) begin
      e_bv[k]   = 1'b0;
      e_sof[k]  = 1'b0;
      e_eof[k]  = 1'b0;
      e_byte[k] = 8'h00;
      if (searching) begin
        if (k - start + 1 >= SYNC_LEN) begin
          d = 0;
          for (int j = 0; j < SYNC_LEN; j++)
            if (strm[k - SYNC_LEN + 1 + j] != sw[SYNC_LEN - 1 - j]) d++;
          if (d <= MAX_ERR) begin
            searching = 1'b0; pstart = k + 1; inv = 1'b0;
          end else if (INV_EN && (SYNC_LEN - d) <= MAX_ERR) begin
            searching = 1'b0; pstart = k + 1; inv = 1'b1;
          end
        end
      end else begin
        p = k - pstart;
        if (p % 8 == 7) begin
          b = p / 8;
          v = 8'h00;
          for (int j = 0; j < 8; j++) v = {v[6:0], strm[pstart + 8 * b + j] ^ inv};
          e_bv[k]   = 1'b1;
          e_byte[k] = v;
          e_sof[k]  = (b == 0);
          e_eof[k]  = (b == FB - 1);
          if (b == FB - 1) begin
            fc = (fc + 1) % 65536;
            m_frames++;
            searching = 1'b1;
            start = k + 1;
          end
        end
      end
      e_lock[k] = !searching;
      e_inv[k]  = inv;
      e_fcnt[k] = 16'(fc);
    end
  endtask

  // Monitor: bit count per posedge, checks on negedge
  int         nbits;
  bit         last_bv;
  logic [7:0] got [$];
  int         lock_cycles;
  int         mk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nbits   = 0;
      last_bv = 1'b0;
    end else begin
      last_bv = bit_val;
      if (bit_val) nbits++;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (nbits == 0) begin
        check("idle_locked", locked, 0);
        check("idle_byte_val", byte_val, 0);
        check("idle_frame_cnt", frame_cnt, 0);
      end else begin
        mk = nbits - 1;
        check("locked", locked, e_lock[mk]);
        check("byte_val", byte_val, last_bv && e_bv[mk]);
        check("frame_cnt", frame_cnt, e_fcnt[mk]);
        check("inverted", inverted, e_inv[mk]);
        if (last_bv && e_bv[mk]) begin
          check("byte_out", byte_out, e_byte[mk]);
          check("sof", sof, e_sof[mk]);
          check("eof", eof, e_eof[mk]);
        end else begin
          check("sof_idle", sof, 0);
          check("eof_idle", eof, 0);
        end
      end
      if (byte_val) got.push_back(byte_out);
      if (locked) lock_cycles++;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_byte_out"}, byte_out, 0);
    check({tag, "_byte_val"}, byte_val, 0);
    check({tag, "_sof"}, sof, 0);
    check({tag, "_eof"}, eof, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_inverted"}, inverted, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
  endtask

  task automatic enter_reset(input string tag);
    reset_n = 1'b0;
    bit_val = 1'b0;
    @(posedge clk); #1;
    check_zero(tag);
  endtask

  task automatic release_reset();
    got.delete();
    lock_cycles = 0;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) body.push_back(w[i]);
  endtask

  function automatic logic [31:0] flips(input int n);
    logic [31:0] m = 32'h0;
    while ($countones(m) < n) m = m | (32'h1 << $urandom_range(0, 31));
    return m;
  endfunction

  // 16 random lead-in bits, retried until the model sees exactly the intended frames
  task automatic build_directed(input int nfr, input int eof_idx);
    bit ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      slen = 0;
      for (int i = 0; i < 16; i++) begin strm[slen] = 1'($urandom); slen++; end
      foreach (body[i]) begin strm[slen] = body[i]; slen++; end
      run_model();
      ok = (m_frames == nfr) && (nfr == 0 || e_eof[eof_idx]);
    end
    check("setup_lead_in", ok, 1);
  endtask

  task automatic send_bit(input bit b, input int gap);
    repeat (gap) begin
      bit_in  = 1'($urandom);
      bit_val = 1'b0;
      @(posedge clk); #1;
    end
    bit_in  = b;
    bit_val = 1'b1;
    @(posedge clk); #1;
    bit_val = 1'b0;
  endtask

  task automatic drive_all(input int gmax);
    for (int i = 0; i < slen; i++) send_bit(strm[i], $urandom_range(0, gmax));
    repeat (10) begin @(posedge clk); #1; end
  endtask

  task automatic check_got(input string tag, input logic [63:0] exp, input int n);
    check({tag, "_count"}, got.size(), n);
    for (int i = 0; i < n; i++)
      if (i < got.size()) check(tag, got[i], exp[8 * (n - 1 - i) +: 8]);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    repeat (3) @(posedge clk); #1;
    check_zero("reset");

    // Clean frame, continuous bit_val
    body.delete(); push_word(sw); push_word(32'hDEADBEEF);
    build_directed(1, 79);
    release_reset();
    drive_all(0);
    check_got("t1_bytes", 64'hDEADBEEF, 4);
    check("t1_frame_cnt", frame_cnt, 1);
    check("t1_lock_cycles", lock_cycles, 32);

    // Two flips accepted, three rejected
    enter_reset("t2_rst");
    body.delete();
    push_word(sw ^ flips(2)); push_word($urandom);
    push_word(sw ^ flips(3)); push_word(32'h0);
    build_directed(1, 79);
    release_reset();
    drive_all(0);
    check("t2_bytes", got.size(), 4);
    check("t2_frame_cnt", frame_cnt, 1);
    check("t2_lock_cycles", lock_cycles, 32);

    // Sparse bit_val, roughly one in twenty cycles
    enter_reset("t3_rst");
    body.delete(); push_word(sw); push_word(32'hDEADBEEF);
    build_directed(1, 79);
    release_reset();
    drive_all(38);
    check_got("t3_bytes", 64'hDEADBEEF, 4);
    check("t3_frame_cnt", frame_cnt, 1);

    // Back-to-back frames; first payload holds the sync word
    enter_reset("t4_rst");
    body.delete();
    push_word(sw); push_word(32'h1ACFFC1D);
    push_word(sw); push_word(32'hDEADBEEF);
    build_directed(2, 143);
    release_reset();
    drive_all(0);
    check_got("t4_bytes", 64'h1ACFFC1D_DEADBEEF, 8);
    check("t4_frame_cnt", frame_cnt, 2);

    // Asynchronous reset just after payload byte 1
    enter_reset("t5_rst");
    body.delete(); push_word(sw); push_word(32'hDEADBEEF);
    build_directed(1, 79);
    release_reset();
    for (int i = 0; i < 64; i++) send_bit(strm[i], 0);
    check("t5_byte1_seen", byte_val, 1);
    #2 reset_n = 1'b0;
    #1 check_zero("t5_async");
    check("t5_bytes_before_reset", got.size(), 1);
    enter_reset("t5_rst2");
    build_directed(1, 79);
    release_reset();
    drive_all(0);
    check_got("t5_bytes", 64'hDEADBEEF, 4);
    check("t5_frame_cnt", frame_cnt, 1);

    // Inverted polarity sync and payload
    enter_reset("t6_rst");
    body.delete(); push_word(32'hE53003E2); push_word(32'h21524110);
    build_directed(INV_EN ? 1 : 0, 79);
    release_reset();
    drive_all(0);
`ifdef FRAME_SYNC_INV_EN
    check_got("t6_bytes", 64'hDEADBEEF, 4);
    check("t6_inverted", inverted, 1);
    check("t6_frame_cnt", frame_cnt, 1);
`else
    check("t6_bytes", got.size(), 0);
    check("t6_frame_cnt", frame_cnt, 0);
    check("t6_lock_cycles", lock_cycles, 0);
`endif

    // Randomized streams: noise, perturbed/inverted syncs, random payloads and duty
    for (int it = 0; it < 6; it++) begin
      logic [31:0] w;
      enter_reset("t7_rst");
      body.delete();
      repeat ($urandom_range(0, 40)) body.push_back(1'($urandom));
      for (int f = 0; f < 3; f++) begin
        w = sw;
        if (INV_EN && $urandom_range(0, 3) == 0) w = ~w;
        push_word(w ^ flips($urandom_range(0, 3)));
        push_word($urandom);
        repeat ($urandom_range(0, 20)) body.push_back(1'($urandom));
      end
      slen = 0;
      foreach (body[i]) begin strm[slen] = body[i]; slen++; end
      run_model();
      nb = 0;
      for (int k = 0; k < slen; k++) if (e_bv[k]) nb++;
      release_reset();
      drive_all((it % 3 == 0) ? 0 : 19);
      check("t7_frame_cnt", frame_cnt, e_fcnt[slen - 1]);
      check("t7_bytes", got.size(), nb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
